fpu_cmp: RTL and testbench

FPU_CMP -- requirements
Module: fpu_cmp

---
 rtl/fpu_cmp.sv | 231 +++++++++++++++++++++++
 tb/tb_fpu_cmp.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpu_cmp.sv
// fpu_cmp: RISC-V F/D sign-injection, min/max and compare unit.
//
// Accepts one FSGNJ/FSGNJN/FSGNJX, FMIN/FMAX or FLE/FLT/FEQ instruction
// (single or double) at a time. The result appears two cycles after the
// op is presented and is held until the issuer moves on.
//
// Ports:
//   clk_i        clock, all state updates on the rising edge
//   reset_i      synchronous active-high reset
//   fpuEnable_i  unit enable; when low instr_i is ignored
//   instr_i      RISC-V instruction, held by the issuer until busy_o drops
//   rs1_i        operand A (single values live in [31:0], box in [63:32])
//   rs2_i        operand B
//   busy_o       op accepted or in flight, result not yet valid
//   fflags_o     {NV,DZ,OF,UF,NX}, valid once busy_o drops after an op
//   fpuOut_o     result, valid once busy_o drops after an op
//
// Build option:
//   FPU_CMP_NANBOX_EN  when defined, single operands whose upper word is not
//                      all ones read as the canonical quiet NaN, and single
//                      FP results are boxed with ffffffff. When undefined the
//                      upper word of single operands is ignored and single
//                      FP results carry zero in [63:32].
module fpu_cmp (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        fpuEnable_i,
    input  logic [31:0] instr_i,
    input  logic [63:0] rs1_i,
    input  logic [63:0] rs2_i,
    output logic        busy_o,
    output logic [4:0]  fflags_o,
    output logic [63:0] fpuOut_o
);

    localparam logic [6:0]  OpFp       = 7'b1010011;
    localparam logic [4:0]  FuncSgnj   = 5'b00100;
    localparam logic [4:0]  FuncMinMax = 5'b00101;
    localparam logic [4:0]  FuncCmp    = 5'b10100;
    localparam logic [31:0] CanonS     = 32'h7fc0_0000;
    localparam logic [63:0] CanonD     = 64'h7ff8_0000_0000_0000;
`ifdef FPU_CMP_NANBOX_EN
    localparam logic [31:0] BoxHi      = 32'hffff_ffff;
`else
    localparam logic [31:0] BoxHi      = 32'h0000_0000;
`endif

    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

    typedef struct packed {
        logic        sign;
        logic [62:0] mag;
        logic        isNan;
        logic        isSnan;
        logic [63:0] bits;
    } operand_t;

    // An op is ours when it is an OP-FP instruction in S or D format with one
    // of the sign-injection, min/max or compare function codes.
    function automatic logic isSupported(input logic [31:0] instr);
        logic funcOk;
        case (instr[31:27])
            FuncSgnj:   funcOk = (instr[14:12] <= 3'd2);
            FuncMinMax: funcOk = (instr[14:12] <= 3'd1);
            FuncCmp:    funcOk = (instr[14:12] <= 3'd2);
            default:    funcOk = 1'b0;
        endcase
        return (instr[6:0] == OpFp) && !instr[26] && funcOk;
    endfunction

    // Splits an operand into sign and magnitude so that both formats can be
    // ordered with one integer comparison; single values are right-aligned.
    function automatic operand_t unpackOperand(input logic [63:0] raw, input logic isDouble);
        operand_t op;
        logic [31:0] word;
        op = '0;
        if (isDouble) begin
            op.sign   = raw[63];
            op.mag    = raw[62:0];
            op.isNan  = (raw[62:52] == 11'h7ff) && (raw[51:0] != '0);
            op.isSnan = op.isNan && !raw[51];
            op.bits   = raw;
        end else begin
            word = raw[31:0];
`ifdef FPU_CMP_NANBOX_EN
            if (raw[63:32] != 32'hffff_ffff) begin
                word = CanonS;
            end
`endif
            op.sign   = word[31];
            op.mag    = {32'h0, word[30:0]};
            op.isNan  = (word[30:23] == 8'hff) && (word[22:0] != '0);
            op.isSnan = op.isNan && !word[22];
            op.bits   = {32'h0, word};
        end
        return op;
    endfunction

    state_t      state_q, state_d;
    logic [31:0] instr_q, instr_d;
    logic [63:0] rs1_q, rs1_d;
    logic [63:0] rs2_q, rs2_d;
    logic [63:0] fpuOut_q, fpuOut_d;
    logic [4:0]  fflags_q, fflags_d;

    logic        isDouble;
    operand_t    opA, opB;
    logic        orderedLt, bothZero, lessThan, equalVal, injSign, opPresented;
    logic [63:0] fpVal, result;
    logic [4:0]  resultFlags;

    // Datapath on the latched operands. orderedLt is a total order where -0
    // sorts below +0, which is what min/max need; the IEEE compares mask that
    // out with bothZero. Only NV can ever be raised by these ops.
    always_comb begin
        isDouble    = instr_q[25];
        opA         = unpackOperand(rs1_q, isDouble);
        opB         = unpackOperand(rs2_q, isDouble);
        orderedLt   = (opA.sign != opB.sign) ? opA.sign
                    : (opA.sign ? (opA.mag > opB.mag) : (opA.mag < opB.mag));
        bothZero    = (opA.mag == '0) && (opB.mag == '0);
        lessThan    = orderedLt && !bothZero;
        equalVal    = bothZero || ((opA.sign == opB.sign) && (opA.mag == opB.mag));
        injSign     = 1'b0;
        fpVal       = '0;
        result      = '0;
        resultFlags = '0;
        case (instr_q[31:27])
            FuncSgnj: begin
                case (instr_q[13:12])
                    2'b00:   injSign = opB.sign;
                    2'b01:   injSign = !opB.sign;
                    default: injSign = opA.sign ^ opB.sign;
                endcase
                fpVal = isDouble ? {injSign, opA.bits[62:0]} : {32'h0, injSign, opA.bits[30:0]};
            end
            FuncMinMax: begin
                resultFlags[4] = opA.isSnan | opB.isSnan;
                if (opA.isNan && opB.isNan) begin
                    fpVal = isDouble ? CanonD : {32'h0, CanonS};
                end else if (opA.isNan) begin
                    fpVal = opB.bits;
                end else if (opB.isNan) begin
                    fpVal = opA.bits;
                end else if (orderedLt ^ instr_q[12]) begin
                    fpVal = opA.bits;
                end else begin
                    fpVal = opB.bits;
                end
            end
            FuncCmp: begin
                if (opA.isNan || opB.isNan) begin
                    resultFlags[4] = instr_q[13] ? (opA.isSnan | opB.isSnan) : 1'b1;
                end else begin
                    case (instr_q[13:12])
                        2'b00:   result[0] = lessThan | equalVal;
                        2'b01:   result[0] = lessThan;
                        default: result[0] = equalVal;
                    endcase
                end
            end
            default: begin
                fpVal = '0;
            end
        endcase
        if (instr_q[31:27] != FuncCmp) begin
            result = isDouble ? fpVal : {BoxHi, fpVal[31:0]};
        end
    end

    // Control: IDLE latches a presented op, EXEC registers the result, DONE
    // holds it until the issuer changes the instruction or drops the enable.
    // busy_o is forced low during reset so an aborted op never looks live.
    always_comb begin
        state_d     = state_q;
        instr_d     = instr_q;
        rs1_d       = rs1_q;
        rs2_d       = rs2_q;
        fpuOut_d    = fpuOut_q;
        fflags_d    = fflags_q;
        opPresented = fpuEnable_i && isSupported(instr_i);
        busy_o      = !reset_i && opPresented && ((state_q == IDLE) || (state_q == EXEC));
        case (state_q)
            IDLE: begin
                if (opPresented) begin
                    instr_d = instr_i;
                    rs1_d   = rs1_i;
                    rs2_d   = rs2_i;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                fpuOut_d = result;
                fflags_d = resultFlags;
                state_d  = DONE;
            end
            DONE: begin
                if (!fpuEnable_i || (instr_i != instr_q)) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset clears everything so an aborted
    // op leaves no trace and a still-presented op is taken again from IDLE.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q  <= IDLE;
            instr_q  <= '0;
            rs1_q    <= '0;
            rs2_q    <= '0;
            fpuOut_q <= '0;
            fflags_q <= '0;
        end else begin
            state_q  <= state_d;
            instr_q  <= instr_d;
            rs1_q    <= rs1_d;
            rs2_q    <= rs2_d;
            fpuOut_q <= fpuOut_d;
            fflags_q <= fflags_d;
        end
    end

    assign fpuOut_o = fpuOut_q;
    assign fflags_o = fflags_q;

endmodule

// File: tb/tb_fpu_cmp.sv
// tb_fpu_cmp: directed bench for fpu_cmp with a value-level reference model.
module tb_fpu_cmp;

`ifdef FPU_CMP_NANBOX_EN
    localparam logic [31:0] BoxHi    = 32'hffff_ffff;
    localparam bit          NanBoxOn = 1'b1;
`else
    localparam logic [31:0] BoxHi    = 32'h0000_0000;
    localparam bit          NanBoxOn = 1'b0;
`endif
    localparam logic [4:0] FSgnj   = 5'b00100;
    localparam logic [4:0] FMinMax = 5'b00101;
    localparam logic [4:0] FCmp    = 5'b10100;
    localparam logic [1:0] FmtS    = 2'b00;
    localparam logic [1:0] FmtD    = 2'b01;

    logic        clk;
    logic        reset;
    logic        fpuEnable;
    logic [31:0] instr;
    logic [63:0] rs1;
    logic [63:0] rs2;
    logic        busy;
    logic [4:0]  fflags;
    logic [63:0] fpuOut;

    logic        checking;
    logic        expBusy;
    logic [63:0] expOut;
    logic [4:0]  expFlags;
    int          checkCount;
    int          errorCount;

    fpu_cmp dut (
        .clk_i       (clk),
        .reset_i     (reset),
        .fpuEnable_i (fpuEnable),
        .instr_i     (instr),
        .rs1_i       (rs1),
        .rs2_i       (rs2),
        .busy_o      (busy),
        .fflags_o    (fflags),
        .fpuOut_o    (fpuOut)
    );

    // Free-running 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case the stimulus ever stalls.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got no finish, expected finish before 500000 ns");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [31:0] mkInstr(input logic [4:0] f5, input logic [1:0] fmt, input logic [2:0] f3);
        return {f5, fmt, 5'd2, 5'd1, f3, 5'd3, 7'b1010011};
    endfunction

    function automatic real pow2(input int n);
        real r;
        r = 1.0;
        if (n >= 0) begin
            for (int i = 0; i < n; i++) r = r * 2.0;
        end else begin
            for (int i = 0; i < -n; i++) r = r * 0.5;
        end
        return r;
    endfunction

    // Numeric value of a single-precision word; infinity maps to 2^128,
    // which still orders above every finite single.
    function automatic real singleToReal(input logic [31:0] w);
        real mag;
        if (w[30:23] == 8'd0) begin
            mag = real'(w[22:0]) * pow2(-149);
        end else begin
            mag = (8388608.0 + real'(w[22:0])) * pow2(int'(w[30:23]) - 150);
        end
        return w[31] ? -mag : mag;
    endfunction

    function automatic logic isNanBits(input logic [63:0] v, input logic dbl);
        if (dbl) return (v[62:52] == 11'h7ff) && (v[51:0] != 52'd0);
        return (v[30:23] == 8'hff) && (v[22:0] != 23'd0);
    endfunction

    function automatic logic isSnanBits(input logic [63:0] v, input logic dbl);
        if (dbl) return isNanBits(v, dbl) && !v[51];
        return isNanBits(v, dbl) && !v[22];
    endfunction

    // Operand as the unit sees it: singles right-aligned, badly boxed
    // singles replaced by the canonical quiet NaN when boxing is enabled.
    function automatic logic [63:0] effOperand(input logic [63:0] v, input logic dbl);
        if (dbl) return v;
        if (NanBoxOn && (v[63:32] != 32'hffff_ffff)) return 64'h0000_0000_7fc0_0000;
        return {32'h0, v[31:0]};
    endfunction

    // Reference model: decides results by comparing real values.
    function automatic void modelOp(input logic [31:0] op, input logic [63:0] a, input logic [63:0] b,
                                    output logic [63:0] res, output logic [4:0] flags);
        logic        dbl, aNan, bNan, aSig, bSig, sa, sb, newSign;
        logic [2:0]  f3;
        logic [63:0] ea, eb, pick;
        real         va, vb;
        dbl   = op[25];
        f3    = op[14:12];
        ea    = effOperand(a, dbl);
        eb    = effOperand(b, dbl);
        aNan  = isNanBits(ea, dbl);
        bNan  = isNanBits(eb, dbl);
        aSig  = isSnanBits(ea, dbl);
        bSig  = isSnanBits(eb, dbl);
        sa    = dbl ? ea[63] : ea[31];
        sb    = dbl ? eb[63] : eb[31];
        va    = dbl ? $bitstoreal(ea) : singleToReal(ea[31:0]);
        vb    = dbl ? $bitstoreal(eb) : singleToReal(eb[31:0]);
        res   = 64'd0;
        flags = 5'd0;
        pick  = ea;
        if (op[31:27] == FSgnj) begin
            newSign = (f3 == 3'd0) ? sb : ((f3 == 3'd1) ? !sb : (sa ^ sb));
            if (dbl) pick[63] = newSign;
            else     pick[31] = newSign;
            res = dbl ? pick : {BoxHi, pick[31:0]};
        end else if (op[31:27] == FMinMax) begin
            flags[4] = aSig | bSig;
            if (aNan && bNan)  pick = dbl ? 64'h7ff8_0000_0000_0000 : 64'h0000_0000_7fc0_0000;
            else if (aNan)     pick = eb;
            else if (bNan)     pick = ea;
            else if (va < vb)  pick = (f3 == 3'd0) ? ea : eb;
            else if (vb < va)  pick = (f3 == 3'd0) ? eb : ea;
            else if (sa != sb) begin
                if (f3 == 3'd0) pick = sa ? ea : eb;
                else            pick = sa ? eb : ea;
            end else           pick = ea;
            res = dbl ? pick : {BoxHi, pick[31:0]};
        end else begin
            if (aNan || bNan) begin
                flags[4] = (f3 == 3'd2) ? (aSig | bSig) : 1'b1;
            end else begin
                case (f3)
                    3'd0:    res[0] = (va <= vb);
                    3'd1:    res[0] = (va < vb);
                    default: res[0] = (va == vb);
                endcase
            end
        end
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    // Compare process: every cycle the DUT outputs must match the bench's
    // expected busy flag and held result.
    always @(negedge clk) begin
        if (checking) begin
            checkOutput("busy", {63'd0, busy}, {63'd0, expBusy});
            checkOutput("fpuOut", fpuOut, expOut);
            checkOutput("fflags", {59'd0, fflags}, {59'd0, expFlags});
        end
    end

    // Presents one op, scrambles the operands during EXEC, checks the result
    // against literals, holds it a cycle, then retires it with a NOP.
    task automatic applyStimulus(input string name, input logic [31:0] op, input logic [63:0] a,
                                 input logic [63:0] b, input logic [63:0] litOut, input logic [4:0] litFlags);
        logic [63:0] mOut;
        logic [4:0]  mFlags;
        modelOp(op, a, b, mOut, mFlags);
        checkOutput({name, " model"}, mOut, litOut);
        checkOutput({name, " model flags"}, {59'd0, mFlags}, {59'd0, litFlags});
        @(posedge clk); #1;
        instr = op; rs1 = a; rs2 = b; fpuEnable = 1'b1; expBusy = 1'b1;
        @(posedge clk); #1;
        rs1 = {$urandom, $urandom}; rs2 = {$urandom, $urandom};
        @(posedge clk); #1;
        expBusy = 1'b0; expOut = mOut; expFlags = mFlags;
        @(negedge clk);
        checkOutput({name, " out"}, fpuOut, litOut);
        checkOutput({name, " flags"}, {59'd0, fflags}, {59'd0, litFlags});
        @(posedge clk); #1;
        @(posedge clk); #1;
        instr = 32'd0;
        @(posedge clk); #1;
    endtask

    initial begin
        logic [63:0] mOut, mOut2;
        logic [4:0]  mFlags, mFlags2;
        logic [31:0] opA, opB;
        checking = 1'b0; checkCount = 0; errorCount = 0;
        reset = 1'b1; fpuEnable = 1'b0; instr = 32'd0; rs1 = 64'd0; rs2 = 64'd0;
        expBusy = 1'b0; expOut = 64'd0; expFlags = 5'd0;

        // Reset state, with a valid op presented to show reset gates busy.
        @(posedge clk); #1;
        checking = 1'b1;
        fpuEnable = 1'b1; instr = mkInstr(FCmp, FmtD, 3'd2);
        @(posedge clk); #1;
        fpuEnable = 1'b0; reset = 1'b0;
        @(posedge clk); #1;
        $display("[TB] directed vectors");

        applyStimulus("fmin_s", mkInstr(FMinMax, FmtS, 3'd0), 64'hffffffff_3f800000, 64'hffffffff_40000000, {BoxHi, 32'h3f800000}, 5'h00);
        applyStimulus("fmax_s_zero", mkInstr(FMinMax, FmtS, 3'd1), 64'hffffffff_80000000, 64'hffffffff_00000000, {BoxHi, 32'h00000000}, 5'h00);
        applyStimulus("fmin_s_zero", mkInstr(FMinMax, FmtS, 3'd0), 64'hffffffff_80000000, 64'hffffffff_00000000, {BoxHi, 32'h80000000}, 5'h00);
        applyStimulus("flt_s_qnan", mkInstr(FCmp, FmtS, 3'd1), 64'hffffffff_7fc00000, 64'hffffffff_3f800000, 64'd0, 5'h10);
        applyStimulus("feq_s_qnan", mkInstr(FCmp, FmtS, 3'd2), 64'hffffffff_7fc00000, 64'hffffffff_3f800000, 64'd0, 5'h00);
        applyStimulus("feq_d", mkInstr(FCmp, FmtD, 3'd2), 64'h3ff0000000000000, 64'h3ff0000000000000, 64'd1, 5'h00);
        applyStimulus("fmin_d_nans", mkInstr(FMinMax, FmtD, 3'd0), 64'h7ff4000000000000, 64'h7ff8000000000001, 64'h7ff8000000000000, 5'h10);
        applyStimulus("fmin_s_box", mkInstr(FMinMax, FmtS, 3'd0), 64'h00000000_3f800000, 64'hffffffff_40000000,
                      NanBoxOn ? 64'hffffffff_40000000 : 64'h00000000_3f800000, 5'h00);
        applyStimulus("fsgnjn_d", mkInstr(FSgnj, FmtD, 3'd1), 64'h3ff0000000000000, 64'h3ff0000000000000, 64'hbff0000000000000, 5'h00);
        applyStimulus("fsgnjx_s", mkInstr(FSgnj, FmtS, 3'd2), 64'hffffffff_bf800000, 64'hffffffff_c0000000, {BoxHi, 32'h3f800000}, 5'h00);
        applyStimulus("fsgnj_s", mkInstr(FSgnj, FmtS, 3'd0), 64'hffffffff_3f800000, 64'hffffffff_c0000000, {BoxHi, 32'hbf800000}, 5'h00);
        applyStimulus("fle_d_zero", mkInstr(FCmp, FmtD, 3'd0), 64'h8000000000000000, 64'h0000000000000000, 64'd1, 5'h00);
        applyStimulus("flt_d_zero", mkInstr(FCmp, FmtD, 3'd1), 64'h8000000000000000, 64'h0000000000000000, 64'd0, 5'h00);
        applyStimulus("feq_s_snan", mkInstr(FCmp, FmtS, 3'd2), 64'hffffffff_7fa00000, 64'hffffffff_3f800000, 64'd0, 5'h10);
        applyStimulus("fmax_d_qnan", mkInstr(FMinMax, FmtD, 3'd1), 64'h7ff8000000000000, 64'hc000000000000000, 64'hc000000000000000, 5'h00);
        applyStimulus("flt_s_neg", mkInstr(FCmp, FmtS, 3'd1), 64'hffffffff_c0000000, 64'hffffffff_bf800000, 64'd1, 5'h00);
        applyStimulus("fle_s_inf", mkInstr(FCmp, FmtS, 3'd0), 64'hffffffff_7f800000, 64'hffffffff_3f800000, 64'd0, 5'h00);
        applyStimulus("fmax_s_snan", mkInstr(FMinMax, FmtS, 3'd1), 64'hffffffff_7f800001, 64'hffffffff_3f800000, {BoxHi, 32'h3f800000}, 5'h10);
        applyStimulus("fmin_d_denorm", mkInstr(FMinMax, FmtD, 3'd0), 64'h0000000000000001, 64'h8000000000000001, 64'h8000000000000001, 5'h00);
        applyStimulus("flt_s_denorm", mkInstr(FCmp, FmtS, 3'd1), 64'hffffffff_00000001, 64'hffffffff_00000002, 64'd1, 5'h00);

        // Unsupported encodings and a disabled unit leave IDLE and outputs alone.
        $display("[TB] unsupported and disabled ops");
        @(posedge clk); #1;
        fpuEnable = 1'b1; instr = mkInstr(FMinMax, 2'b10, 3'd0); expBusy = 1'b0;
        @(posedge clk); #1;
        instr = mkInstr(FMinMax, FmtS, 3'd2);
        @(posedge clk); #1;
        instr = mkInstr(FCmp, FmtD, 3'd3);
        @(posedge clk); #1;
        instr = {mkInstr(FCmp, FmtD, 3'd2) & 32'hffffff80} | 32'h57;
        @(posedge clk); #1;
        fpuEnable = 1'b0; instr = mkInstr(FCmp, FmtD, 3'd2); rs1 = 64'd0; rs2 = 64'd0;
        @(posedge clk); #1;
        @(posedge clk); #1;

        // A new op presented in DONE is taken after one cycle back in IDLE;
        // dropping the enable in DONE also returns to IDLE.
        $display("[TB] handoff in DONE");
        opA = mkInstr(FMinMax, FmtD, 3'd1);
        opB = mkInstr(FSgnj, FmtD, 3'd0);
        modelOp(opA, 64'h4000000000000000, 64'h3ff0000000000000, mOut, mFlags);
        modelOp(opB, 64'h4000000000000000, 64'hbff0000000000000, mOut2, mFlags2);
        checkOutput("handoff model", mOut2, 64'hc000000000000000);
        @(posedge clk); #1;
        fpuEnable = 1'b1; instr = opA; rs1 = 64'h4000000000000000; rs2 = 64'h3ff0000000000000; expBusy = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        expBusy = 1'b0; expOut = mOut; expFlags = mFlags;
        instr = opB; rs2 = 64'hbff0000000000000;
        @(posedge clk); #1;
        expBusy = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        expBusy = 1'b0; expOut = mOut2; expFlags = mFlags2;
        @(posedge clk); #1;
        fpuEnable = 1'b0;
        @(posedge clk); #1;
        fpuEnable = 1'b1; rs2 = 64'h3ff0000000000000; expBusy = 1'b1;
        modelOp(opB, 64'h4000000000000000, 64'h3ff0000000000000, mOut2, mFlags2);
        @(posedge clk); #1;
        @(posedge clk); #1;
        expBusy = 1'b0; expOut = mOut2; expFlags = mFlags2;
        @(posedge clk); #1;
        instr = 32'd0;
        @(posedge clk); #1;

        // Reset while EXEC aborts the op; the held op is accepted again.
        $display("[TB] reset during EXEC");
        applyStimulus("pre_reset", mkInstr(FCmp, FmtD, 3'd0), 64'h3ff0000000000000, 64'h4000000000000000, 64'd1, 5'h00);
        opA = mkInstr(FMinMax, FmtS, 3'd0);
        modelOp(opA, 64'hffffffff_c0400000, 64'hffffffff_40400000, mOut, mFlags);
        @(posedge clk); #1;
        instr = opA; rs1 = 64'hffffffff_c0400000; rs2 = 64'hffffffff_40400000; expBusy = 1'b1;
        @(posedge clk); #1;
        reset = 1'b1; expBusy = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0; expBusy = 1'b1; expOut = 64'd0; expFlags = 5'd0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        expBusy = 1'b0; expOut = mOut; expFlags = mFlags;
        @(negedge clk);
        checkOutput("after_reset out", fpuOut, {BoxHi, 32'hc0400000});
        @(posedge clk); #1;
        instr = 32'd0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        checking = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
